// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package mole_round_ctrl_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Galois taps for x^8+x^6+x^5+x^4+1 in right-shift form
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    // One step of the right-shifting Galois LFSR
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/mole_round_ctrl_lfsr8.sv
// Free-running 8-bit Galois LFSR used as the mole picker's entropy source.
// Latency: new value every clock; q is the registered state.
// Backpressure: none, it never stalls.
module lfsr8
    import mole_round_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // Step every clock; a zero seed would lock up, so callers keep SEED nonzero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Game-round sequencer: lights one mole per round, reloads the timer, scores hits.
// Latency: start -> ARM (mole + tmr_load) next cycle; hit/timeout -> next ARM or DONE next cycle.
// Backpressure: none; start is dropped outside IDLE/DONE, non-matching hits are dropped.
module mole_round_ctrl
    import mole_round_ctrl_pkg::*;
#(
    parameter int         NUM_MOLES  = 4,
    parameter int         NUM_ROUNDS = 8,
    parameter int         SCORE_W    = 8,
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit,
    input  logic                 tmr_running,
    input  logic                 tmr_timeout,
    output logic                 tmr_load,
    output logic [NUM_MOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           round,
    output logic                 game_over
);

    localparam int                   IDX_W      = $clog2(NUM_MOLES);
    localparam logic [3:0]           LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [SCORE_W-1:0]   SCORE_MAX  = '1;
    localparam logic [NUM_MOLES-1:0] ONE        = NUM_MOLES'(1);

    logic [1:0]         state;
    logic [7:0]         lfsr_q;
    logic [IDX_W-1:0]   raw_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   prev_idx;
    logic [SCORE_W-1:0] score_inc;
    logic               hit_ok;

    // The timer's running flag is informational only, and only the low
    // LFSR bits feed the picker; fold them here so they are visibly consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, tmr_running, lfsr_q[7:IDX_W]};

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign raw_idx   = lfsr_q[IDX_W-1:0];
    assign hit_ok    = |(hit & mole);
    assign score_inc = (score == SCORE_MAX) ? score : score + 1'b1;

    // Bump the pick by one when it would repeat the last round's mole;
    // NUM_MOLES is a power of two so the add wraps naturally.
    always_comb begin
        next_idx = raw_idx;
        if (raw_idx == prev_idx) begin
            next_idx = raw_idx + 1'b1;
        end
    end

    // Round sequencer: all outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mole      <= '0;
            score     <= '0;
            round     <= '0;
            tmr_load  <= 1'b0;
            game_over <= 1'b0;
            prev_idx  <= '0;
        end else begin
            tmr_load <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // First round of a game has no previous mole to avoid
                    if (start) begin
                        state     <= ST_ARM;
                        mole      <= ONE << raw_idx;
                        prev_idx  <= raw_idx;
                        score     <= '0;
                        round     <= 4'd1;
                        tmr_load  <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                ST_ARM: begin
                    // Timer reloads at the end of this cycle; any timeout
                    // seen now is stale from the previous round.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A matching hit beats a simultaneous timeout
                    if (hit_ok || tmr_timeout) begin
                        if (hit_ok) begin
                            score <= score_inc;
                        end
                        if (round == LAST_ROUND) begin
                            state     <= ST_DONE;
                            mole      <= '0;
                            game_over <= 1'b1;
                        end else begin
                            state    <= ST_ARM;
                            round    <= round + 4'd1;
                            mole     <= ONE << next_idx;
                            prev_idx <= next_idx;
                            tmr_load <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl with a countdown timer stub.
// Latency: checks every cycle against a scoreboard of expected outputs.
// Backpressure: n/a.
module tb_mole_round_ctrl;

    localparam int NM = 4;
    localparam int NR = 5;
    localparam int SW = 2;
    localparam int TMR_INIT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NM-1:0] hit = '0;
    logic          tmr_running;
    logic          tmr_timeout;
    logic          tmr_load;
    logic [NM-1:0] mole;
    logic [SW-1:0] score;
    logic [3:0]    round;
    logic          game_over;

    logic force_to = 1'b0;
    int   tcnt;

    int checks = 0;
    int errors = 0;

    mole_round_ctrl #(
        .NUM_MOLES  (NM),
        .NUM_ROUNDS (NR),
        .SCORE_W    (SW),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hit         (hit),
        .tmr_running (tmr_running),
        .tmr_timeout (tmr_timeout),
        .tmr_load    (tmr_load),
        .mole        (mole),
        .score       (score),
        .round       (round),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Countdown timer stub; force_to lets the bench inject a timeout
    always @(posedge clk or posedge rst) begin
        if (rst)           tcnt <= 0;
        else if (tmr_load) tcnt <= TMR_INIT;
        else if (tcnt > 0) tcnt <= tcnt - 1;
    end
    assign tmr_running = (tcnt != 0);
    assign tmr_timeout = (tcnt == 0) || force_to;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [NM-1:0] mole;
        logic [SW-1:0] score;
        logic [3:0]    round;
        logic          ld;
        logic          go;
    } exp_t;

    exp_t sbq[$];

    int            m_state;   // 0 idle, 1 arm, 2 wait, 3 done
    logic [NM-1:0] m_mole;
    logic [SW-1:0] m_score;
    logic [3:0]    m_round;
    logic          m_ld;
    logic          m_go;
    logic [7:0]    m_lfsr;
    logic [1:0]    m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_mole = '0; m_score = '0; m_round = '0;
        m_ld = 1'b0; m_go = 1'b0; m_lfsr = 8'hA5; m_prev = 2'd0;
    endtask

    task automatic model_light(input logic [1:0] idx);
        m_prev  = idx;
        m_mole  = 4'b0001 << idx;
        m_ld    = 1'b1;
        m_state = 1;
    endtask

    // Advance the model by one clock edge and push the outputs it predicts
    task automatic model_step(input logic s, input logic [NM-1:0] h, input logic to);
        logic [7:0] cur;
        logic [1:0] idx;
        logic       hm;
        exp_t       e;
        cur    = m_lfsr;
        m_lfsr = {1'b0, cur[7:1]} ^ (cur[0] ? 8'hB8 : 8'h00);
        m_ld   = 1'b0;
        hm     = |(h & m_mole);
        case (m_state)
            0, 3: if (s) begin
                model_light(cur[1:0]);
                m_score = '0; m_round = 4'd1; m_go = 1'b0;
            end
            1: m_state = 2;
            2: if (hm || to) begin
                if (hm && m_score != 2'd3) m_score = m_score + 2'd1;
                if (m_round == 4'(NR)) begin
                    m_state = 3; m_mole = '0; m_go = 1'b1;
                end else begin
                    idx = cur[1:0];
                    if (idx == m_prev) idx = idx + 2'd1;
                    m_round = m_round + 4'd1;
                    model_light(idx);
                end
            end
            default: ;
        endcase
        e.mole = m_mole; e.score = m_score; e.round = m_round; e.ld = m_ld; e.go = m_go;
        sbq.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            chk("sb_mole",  32'(mole),      32'(e.mole));
            chk("sb_score", 32'(score),     32'(e.score));
            chk("sb_round", 32'(round),     32'(e.round));
            chk("sb_load",  32'(tmr_load),  32'(e.ld));
            chk("sb_over",  32'(game_over), 32'(e.go));
        end
    endtask

    // One clock: hk 0=no hit, 1=matching hit, 2=non-matching hit
    task automatic cyc(input logic s, input int hk, input logic f);
        logic [NM-1:0] h;
        case (hk)
            1:       h = m_mole;
            2:       h = {m_mole[2:0], m_mole[3]};
            default: h = '0;
        endcase
        start = s; hit = h; force_to = f;
        model_step(s, h, (tcnt == 0) || f);
        @(posedge clk);
        @(negedge clk);
        sb_check();
        start = 1'b0; hit = '0; force_to = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       s;
        int         hk;
        logic       f;
        logic [1:0] score;
        logic [3:0] round;
        logic       ld;
        logic       go;
    } vec_t;

    function automatic vec_t v(input logic s, input int hk, input logic f,
                               input int sc, input int rd, input logic ld, input logic go);
        vec_t r;
        r.s = s; r.hk = hk; r.f = f; r.score = 2'(sc); r.round = 4'(rd); r.ld = ld; r.go = go;
        return r;
    endfunction

    vec_t tv[17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            loads;
        int            rounds;
        logic [NM-1:0] seen;
        logic [NM-1:0] last;

        tv[0]  = v(0, 0, 0, 0, 0, 0, 0);  // idle stays idle
        tv[1]  = v(1, 0, 0, 0, 1, 1, 0);  // start -> ARM
        tv[2]  = v(0, 1, 0, 0, 1, 0, 0);  // hit and stale timeout in ARM ignored
        tv[3]  = v(0, 0, 0, 0, 1, 0, 0);
        tv[4]  = v(0, 2, 0, 0, 1, 0, 0);  // wrong button ignored
        tv[5]  = v(0, 1, 0, 1, 2, 1, 0);  // correct hit
        tv[6]  = v(1, 0, 0, 1, 2, 0, 0);  // start ignored in ARM
        tv[7]  = v(1, 0, 0, 1, 2, 0, 0);  // start ignored in WAIT
        tv[8]  = v(0, 1, 1, 2, 3, 1, 0);  // hit beats timeout
        tv[9]  = v(0, 0, 0, 2, 3, 0, 0);
        tv[10] = v(0, 0, 1, 2, 4, 1, 0);  // timeout miss
        tv[11] = v(0, 0, 0, 2, 4, 0, 0);
        tv[12] = v(0, 1, 0, 3, 5, 1, 0);
        tv[13] = v(0, 0, 0, 3, 5, 0, 0);
        tv[14] = v(0, 1, 0, 3, 5, 0, 1);  // saturates, last round -> DONE
        tv[15] = v(0, 0, 0, 3, 5, 0, 1);  // DONE holds
        tv[16] = v(1, 0, 0, 0, 1, 1, 0);  // restart from DONE

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_mole",  32'(mole),      0);
        chk("rst_score", 32'(score),     0);
        chk("rst_round", 32'(round),     0);
        chk("rst_load",  32'(tmr_load),  0);
        chk("rst_over",  32'(game_over), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tv[i].s, tv[i].hk, tv[i].f);
            chk($sformatf("vec%0d_score", i), 32'(score),     32'(tv[i].score));
            chk($sformatf("vec%0d_round", i), 32'(round),     32'(tv[i].round));
            chk($sformatf("vec%0d_load", i),  32'(tmr_load),  32'(tv[i].ld));
            chk($sformatf("vec%0d_over", i),  32'(game_over), 32'(tv[i].go));
            chk($sformatf("vec%0d_onehot", i), 32'($onehot(mole) || tv[i].go || (tv[i].round == 0)), 1);
        end

        // Let the restarted game run out on timeouts
        for (int i = 0; i < 400 && !m_go; i++) cyc(0, 0, 0);
        chk("drain_over", 32'(game_over), 1);

        // Full game with no hits: one reload per round, nothing scored
        loads = 0;
        cyc(1, 0, 0);
        if (tmr_load) loads++;
        for (int i = 0; i < 400 && !game_over; i++) begin
            cyc(0, 0, 0);
            if (tmr_load) loads++;
        end
        chk("to_loads", 32'(loads),     32'(NR));
        chk("to_score", 32'(score),     0);
        chk("to_over",  32'(game_over), 1);
        chk("to_mole",  32'(mole),      0);

        // 50 rounds of forced hits: one-hot, no back-to-back repeat, full coverage
        seen = '0; rounds = 0; last = '0;
        for (int g = 0; g < 50 / NR; g++) begin
            cyc(1, 0, 0);
            for (int i = 0; i < 100; i++) begin
                if (tmr_load) begin
                    rounds++;
                    chk("seq_onehot", 32'($onehot(mole)), 1);
                    if (round != 4'd1) chk("seq_norepeat", 32'(mole != last), 1);
                    seen = seen | mole;
                    last = mole;
                end
                if (m_go) break;
                cyc(0, (m_state == 2) ? 1 : 0, 0);
            end
            chk("seq_score", 32'(score), 3);
        end
        chk("seq_rounds", 32'(rounds), 50);
        chk("seq_seen",   32'(seen),   32'hF);

        // Reset while waiting for a hit
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_mole",  32'(mole),      0);
        chk("mid_rst_score", 32'(score),     0);
        chk("mid_rst_round", 32'(round),     0);
        chk("mid_rst_load",  32'(tmr_load),  0);
        chk("mid_rst_over",  32'(game_over), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("mid_rst_sbq", 32'(sbq.size()), 0);
        loads = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0);
            if (tmr_load) loads++;
        end
        chk("post_rst_loads", 32'(loads), 0);
        cyc(1, 0, 0);
        chk("post_rst_start_load", 32'(tmr_load), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
